pc_sequencer: RTL

- Owns the program counter register of the single-cycle RV32I core.
- Sequences every PC update: sequential fetch (PC+4), branch/JAL redirect (PC+imm), JALR redirect ((rs1+imm)&~1).
- Applies stall holds and halts on misaligned targets.
- Sits between decode/branch-compare and instruction memory; keeps a retired-instruction count.

---
 rtl/pc_sequencer.sv | 118 +++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// ============================================================================
//  Module   : pc_sequencer
//  Purpose  : Program-counter owner for the single-cycle RV32I core. Selects
//             sequential / branch / JAL / JALR next-PC, honours stalls,
//             halts on misaligned redirect targets, counts retirements.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          XLEN         = 32,
  // Value instret takes on reset; left at zero for the core.
  parameter logic [31:0] INSTRET_INIT = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            branch_taken_i,
  input  logic            jal_i,
  input  logic            jalr_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] rs1_val_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic [XLEN-1:0] target_o,
  output logic            redirect_o,
  output logic            instr_valid_o,
  output logic            misalign_trap_o,
  output logic [XLEN-1:0] instret_o
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [XLEN-1:0] ONE       = XLEN'(1);
  localparam logic [XLEN-1:0] FOUR      = XLEN'(4);
  localparam logic [XLEN-1:0] LSB_CLEAR = ~ONE;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instret_q, instret_d;
  logic            trap_q, trap_d;

  logic            src_active;
  logic            misalign;
  logic [XLEN-1:0] jalr_tgt;
  logic [XLEN-1:0] rel_tgt;

  // Redirect target selection: jalr outranks jal/branch, which share pc+imm.
  always_comb begin
    jalr_tgt   = (rs1_val_i + imm_i) & LSB_CLEAR;
    rel_tgt    = pc_q + imm_i;
    pc_plus4_o = pc_q + FOUR;
    src_active = jalr_i | jal_i | branch_taken_i;
    if (jalr_i)
      target_o = jalr_tgt;
    else if (jal_i || branch_taken_i)
      target_o = rel_tgt;
    else
      target_o = pc_plus4_o;
    // Only a redirect can produce bit1 set; sequential fetch stays aligned.
    misalign   = src_active & target_o[1];
  end

  // Outputs that depend on the sequencing state.
  always_comb begin
    instr_valid_o   = (state_q == ST_RUN);
    redirect_o      = (state_q == ST_RUN) & ~stall_i & src_active;
    pc_o            = pc_q;
    instret_o       = instret_q;
    misalign_trap_o = trap_q;
  end

  // Next-state logic: BOOT bubble, RUN sequencing, HALT freeze.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instret_d = instret_q;
    trap_d    = trap_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (!stall_i) begin
          if (misalign) begin
            // Faulting instruction neither updates pc nor retires.
            trap_d  = 1'b1;
            state_d = ST_HALT;
          end else begin
            pc_d      = src_active ? target_o : pc_plus4_o;
            instret_d = instret_q + ONE;
          end
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase
  end

  // State registers; reset overrides any pending redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_BOOT;
      pc_q      <= RESET_VECTOR;
      instret_q <= INSTRET_INIT;
      trap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instret_q <= instret_d;
      trap_q    <= trap_d;
    end
  end

endmodule

`default_nettype wire
